// File: rtl/carfield_l2_port_arbiter.sv
// carfield_l2_port_arbiter
//
// Shares one Carfield L2 port among NumReq requesters (safety island,
// security island, integer cluster). Requests are arbitrated round-robin,
// range-checked against the port window [PortBase, PortBase+PortSize), and
// forwarded on a TCDM-style req/gnt/rvalid memory interface. A small FIFO of
// requester ids routes the in-order memory responses back to their owners.
// Out-of-range requests never reach memory; they are answered locally with
// an error response one cycle after their grant.
//
// Optional feature macro: CARFIELD_L2_ARB_QOS_EN
//   defined   -> requester 0 has absolute priority (lock still wins),
//                round-robin among requesters 1..NumReq-1
//   undefined -> pure round-robin over all requesters
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i/addr_i/we_i/
//   wdata_i/be_i            per-requester request and payload (flattened)
//   gnt_o                   one-hot grant to the requester
//   rvalid_o/rdata_o/err_o  one-hot response valid, shared data, error flag
//   mem_req_o/mem_gnt_i     memory request handshake
//   mem_addr_o              address relative to PortBase
//   mem_we_o/mem_wdata_o/
//   mem_be_o                forwarded payload of the selected requester
//   mem_rvalid_i/
//   mem_rdata_i             in-order memory response
//   dbg_rsp_err             response FSM state (1 = error response slot)
//
// Handshake semantics: a requester raises req_i with a stable payload and
// holds both until the cycle in which gnt_o for it is high; that cycle is the
// transfer. On the memory side the transfer happens in every cycle where
// mem_req_o and mem_gnt_i are both high; once mem_req_o is raised for a
// winner it stays on that winner until the transfer. Every transfer, read or
// write, yields exactly one response (rvalid_o), in order.

module carfield_l2_port_arbiter #(
    parameter int                      NumReq         = 3,
    parameter int                      AddrWidth      = 48,
    parameter int                      DataWidth      = 64,
    parameter int                      MaxOutstanding = 4,
    parameter logic [AddrWidth-1:0]    PortBase       = 'h7800_0000,
    parameter logic [AddrWidth-1:0]    PortSize       = 'h20_0000
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_i,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    input  logic [NumReq*DataWidth/8-1:0]   be_i,
    output logic [NumReq-1:0]               gnt_o,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            err_o,
    output logic                            mem_req_o,
    input  logic                            mem_gnt_i,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic                            mem_we_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    input  logic                            mem_rvalid_i,
    input  logic [DataWidth-1:0]            mem_rdata_i,
    output logic                            dbg_rsp_err
);

    localparam int BeWidth = DataWidth / 8;
    localparam int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int FifoAw  = $clog2(MaxOutstanding);
    localparam int CntW    = $clog2(MaxOutstanding + 1);
    localparam logic [AddrWidth-1:0] PortEnd = PortBase + PortSize;

    typedef enum logic {
        IDLE    = 1'b0,
        RSP_ERR = 1'b1
    } rsp_state_e;

    rsp_state_e          state_q, state_d;
    logic [IdWidth-1:0]  ptr_q;
    logic                lock_q;
    logic [IdWidth-1:0]  lock_id_q;
    logic [IdWidth-1:0]  err_id_q;

    logic [IdWidth-1:0]  fifo_id_q [MaxOutstanding];
    logic [FifoAw-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;

    logic                win_valid;
    logic [IdWidth-1:0]  win_id;
    logic [AddrWidth-1:0] sel_addr;
    logic                in_range;
    logic                fifo_empty, fifo_full;
    logic                pop, mem_req, hs, err_grant;

    // ------------------------------------------------------------------
    // Winner selection. A winner that has already raised mem_req_o without
    // a grant stays the winner, so later requests cannot preempt it.
    // ------------------------------------------------------------------
    always_comb begin
        int                 idx;
        logic [IdWidth-1:0] cand;
        win_valid = 1'b0;
        win_id    = '0;
        idx       = 0;
        cand      = '0;
        if (lock_q) begin
            win_valid = 1'b1;
            win_id    = lock_id_q;
        end
`ifdef CARFIELD_L2_ARB_QOS_EN
        else if (req_i[0]) begin
            win_valid = 1'b1;
            win_id    = '0;
        end else begin
            // Round-robin over 1..NumReq-1; a pointer of 0 starts at 1.
            for (int i = 0; i < NumReq - 1; i++) begin
                idx = ((ptr_q == '0) ? 1 : int'(ptr_q)) + i;
                if (idx >= NumReq) idx = idx - (NumReq - 1);
                cand = IdWidth'(idx);
                if (!win_valid && req_i[cand]) begin
                    win_valid = 1'b1;
                    win_id    = cand;
                end
            end
        end
`else
        else begin
            for (int i = 0; i < NumReq; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NumReq) idx = idx - NumReq;
                cand = IdWidth'(idx);
                if (!win_valid && req_i[cand]) begin
                    win_valid = 1'b1;
                    win_id    = cand;
                end
            end
        end
`endif
    end

    assign sel_addr   = addr_i[int'(win_id)*AddrWidth +: AddrWidth];
    assign in_range   = (sel_addr >= PortBase) && (sel_addr < PortEnd);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(MaxOutstanding));
    // The FIFO is always empty in RSP_ERR, so a pop can only happen in IDLE.
    assign pop        = (state_q == IDLE) && mem_rvalid_i && !fifo_empty;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign mem_req    = win_valid && in_range && (!fifo_full || pop);
    assign hs         = mem_req && mem_gnt_i;
    // Local error grants wait until no memory response is pending and the
    // error slot is free, so the error response can never collide.
    assign err_grant  = win_valid && !in_range && fifo_empty && (state_q == IDLE);

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (!rst_i) begin
            if (hs || err_grant) gnt_o = NumReq'(1) << win_id;
            mem_req_o = mem_req;
            if (mem_req) begin
                mem_addr_o  = sel_addr - PortBase;
                mem_we_o    = we_i[win_id];
                mem_wdata_o = wdata_i[int'(win_id)*DataWidth +: DataWidth];
                mem_be_o    = be_i[int'(win_id)*BeWidth +: BeWidth];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FSM: next state and response outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (err_grant) state_d = RSP_ERR;
                if (pop && !rst_i) begin
                    rvalid_o = NumReq'(1) << fifo_id_q[rd_ptr_q];
                    rdata_o  = mem_rdata_i;
                end
            end
            RSP_ERR: begin
                state_d = IDLE;
                if (!rst_i) begin
                    rvalid_o = NumReq'(1) << err_id_q;
                    err_o    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_rsp_err = (state_q == RSP_ERR);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_id_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hs || err_grant) begin
                ptr_q <= (win_id == IdWidth'(NumReq - 1)) ? '0 : win_id + IdWidth'(1);
            end
            if (err_grant) err_id_q <= win_id;
            if (hs) begin
                lock_q <= 1'b0;
            end else if (mem_req) begin
                lock_q    <= 1'b1;
                lock_id_q <= win_id;
            end
            if (hs) begin
                wr_ptr_q <= (wr_ptr_q == FifoAw'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + FifoAw'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == FifoAw'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + FifoAw'(1);
            end
            count_q <= count_q + CntW'(hs) - CntW'(pop);
        end
    end

    // FIFO storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk_i) begin
        if (hs) fifo_id_q[wr_ptr_q] <= win_id;
    end

`ifndef SYNTHESIS
    // A memory response without an outstanding request is a protocol error
    // on the memory side; the RTL ignores it.
    rvalid_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> !fifo_empty)
        else $error("mem_rvalid_i with no outstanding transaction");
`endif

endmodule

// File: tb/tb_carfield_l2_port_arbiter.sv
module tb_carfield_l2_port_arbiter;

  localparam int N    = 3;
  localparam int AW   = 48;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;
  localparam int MAXO = 4;
  localparam logic [AW-1:0] BASE = 48'h7800_0000;
  localparam logic [AW-1:0] SIZE = 48'h20_0000;
`ifdef CARFIELD_L2_ARB_QOS_EN
  localparam bit QOS = 1'b1;
`else
  localparam bit QOS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   addr;
  logic [N-1:0]      we;
  logic [N*DW-1:0]   wdata;
  logic [N*BW-1:0]   be;
  logic [N-1:0]      gnt;
  logic [N-1:0]      rvalid;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              mem_req;
  logic              mem_gnt;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;
  logic [BW-1:0]     mem_be;
  logic              mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  logic              dbg_rsp_err;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  carfield_l2_port_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO),
    .PortBase(BASE), .PortSize(SIZE)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .dbg_rsp_err(dbg_rsp_err)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req = '0; addr = '0; we = '0; wdata = '0; be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    req[i] = 1'b1;
    addr[i*AW +: AW] = a;
    we[i] = w;
    wdata[i*DW +: DW] = d;
    be[i*BW +: BW] = b;
  endtask

  task automatic drop_req(input int i);
    req[i] = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge (settle).
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [1:0]      exp_q[$];      // requester ids with a memory response owed
  int              m_ptr;
  int              m_lock;        // -1: no lock
  int              m_err;         // -1: no error response due this cycle
  bit              act [N];
  logic [AW-1:0]   p_addr [N];
  logic            p_we [N];
  logic [DW-1:0]   p_wdata [N];
  logic [BW-1:0]   p_be [N];

  function automatic bit in_window(input logic [AW-1:0] a);
    return (a >= BASE) && (a - BASE < SIZE);
  endfunction

  // Winner from the arbitration rules: lock first, then (optionally)
  // requester 0, then the first active requester scanning from the pointer.
  function automatic int model_winner();
    int cand[$];
    int start;
    if (m_lock >= 0) return m_lock;
    if (QOS && act[0]) return 0;
    cand = {};
    if (QOS) begin
      start = (m_ptr == 0) ? 1 : m_ptr;
      for (int k = 0; k < N - 1; k++) cand.push_back(1 + ((start - 1 + k) % (N - 1)));
    end else begin
      for (int k = 0; k < N; k++) cand.push_back((m_ptr + k) % N);
    end
    foreach (cand[j]) if (act[cand[j]]) return cand[j];
    return -1;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 9))
      0: a = BASE - AW'($urandom_range(1, 4096));
      1: a = BASE + SIZE + AW'($urandom_range(0, 4096));
      2: a = BASE;
      3: a = BASE + SIZE - 1;
      4: a = 48'h1_0000_0000 + BASE;
      default: a = BASE + AW'({$urandom_range(0, 'h3FFFF), 3'b000});
    endcase
    return a;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    req = '1;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = BASE + AW'(i * 8);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = '1;
    @(posedge clk); #1; settle();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt got %b exp 000", gnt); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
    checks++; if (rvalid !== '0 || err !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL rst_rsp got rv %b err %b rdata %h exp 0", rvalid, err, rdata); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0 || dbg_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_payload got addr %h wdata %h dbg %b exp 0", mem_addr, mem_wdata, dbg_rsp_err); end
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    settle();
    checks++; if (gnt !== '0 || mem_req !== 1'b0 || rvalid !== '0 || err !== 1'b0) begin errors++; $display("FAIL post_rst_idle got gnt %b mreq %b rv %b err %b exp 0", gnt, mem_req, rvalid, err); end
  endtask

  task automatic test_sequential();
    logic [N-1:0] e;
    int ew, pw;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, BASE + AW'(16 + i * 256), 1'b0, '0, '0);
    mem_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mem_rvalid = (k > 0);
      mem_rdata = DW'(8'hD0 + k);
      settle();
      ew = QOS ? 0 : k % 3;
      pw = QOS ? 0 : (k + 2) % 3;
      e = N'(1) << ew;
      checks++; if (gnt !== e) begin errors++; $display("FAIL seq_gnt k=%0d got %b exp %b", k, gnt, e); end
      if (ew == 0) begin
        checks++; if (mem_addr !== 48'h10) begin errors++; $display("FAIL seq_addr k=%0d got %h exp 10", k, mem_addr); end
      end
      if (k > 0) begin
        e = N'(1) << pw;
        checks++; if (rvalid !== e || rdata !== DW'(8'hD0 + k)) begin errors++; $display("FAIL seq_rsp k=%0d got %b/%h exp %b/%h", k, rvalid, rdata, e, DW'(8'hD0 + k)); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    set_req(1, 48'h7900_0000, 1'b0, '0, '0);
    settle();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL oor_gnt got %b exp 010", gnt); end
    checks++; if (mem_req !== 1'b0 || rvalid !== '0) begin errors++; $display("FAIL oor_t0 got mreq %b rv %b exp 0", mem_req, rvalid); end
    next_cycle();
    drop_req(1);
    settle();
    checks++; if (rvalid !== 3'b010 || err !== 1'b1 || rdata !== '0) begin errors++; $display("FAIL oor_rsp got rv %b err %b rdata %h exp 010 1 0", rvalid, err, rdata); end
    checks++; if (mem_req !== 1'b0 || gnt !== '0 || dbg_rsp_err !== 1'b1) begin errors++; $display("FAIL oor_t1 got mreq %b gnt %b dbg %b exp 0 000 1", mem_req, gnt, dbg_rsp_err); end
    next_cycle();
    settle();
    checks++; if (rvalid !== '0 || err !== 1'b0) begin errors++; $display("FAIL oor_t2 got rv %b err %b exp 0", rvalid, err); end
  endtask

  task automatic test_boundary();
    do_reset();
    set_req(0, BASE + SIZE - 1, 1'b0, '0, '0);
    settle();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 48'h1F_FFFF || gnt !== '0) begin errors++; $display("FAIL bnd_top got mreq %b addr %h gnt %b exp 1 1fffff 000", mem_req, mem_addr, gnt); end
    next_cycle(); mem_gnt = 1'b1; settle();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL bnd_top_gnt got %b exp 001", gnt); end
    next_cycle(); drop_req(0); mem_gnt = 1'b0;
    set_req(1, BASE + SIZE, 1'b0, '0, '0);
    settle();
    checks++; if (gnt !== '0 || mem_req !== 1'b0) begin errors++; $display("FAIL bnd_end_wait got gnt %b mreq %b exp 000 0", gnt, mem_req); end
    next_cycle(); mem_rvalid = 1'b1; mem_rdata = 64'h55; settle();
    checks++; if (rvalid !== 3'b001 || rdata !== 64'h55 || gnt !== '0) begin errors++; $display("FAIL bnd_drain got rv %b rdata %h gnt %b exp 001 55 000", rvalid, rdata, gnt); end
    next_cycle(); mem_rvalid = 1'b0; settle();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL bnd_end_gnt got %b exp 010", gnt); end
    next_cycle(); drop_req(1);
    set_req(2, BASE - 1, 1'b0, '0, '0);
    settle();
    checks++; if (rvalid !== 3'b010 || err !== 1'b1 || gnt !== '0) begin errors++; $display("FAIL bnd_err1 got rv %b err %b gnt %b exp 010 1 000", rvalid, err, gnt); end
    next_cycle(); settle();
    checks++; if (gnt !== 3'b100 || mem_req !== 1'b0) begin errors++; $display("FAIL bnd_low_gnt got %b mreq %b exp 100 0", gnt, mem_req); end
    next_cycle(); drop_req(2); settle();
    checks++; if (rvalid !== 3'b100 || err !== 1'b1) begin errors++; $display("FAIL bnd_err2 got rv %b err %b exp 100 1", rvalid, err); end
    next_cycle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    set_req(0, BASE + 48'h40, 1'b1, 64'hCAFE_F00D_1234_5678, 8'hA5);
    mem_gnt = 1'b1;
    for (int k = 0; k < MAXO; k++) begin
      settle();
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL full_fill k=%0d got %b exp 001", k, gnt); end
      next_cycle();
    end
    settle();
    checks++; if (mem_req !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL full_block got mreq %b gnt %b exp 0 000", mem_req, gnt); end
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 64'h11;
    settle();
    checks++; if (mem_req !== 1'b1 || gnt !== 3'b001 || rvalid !== 3'b001) begin errors++; $display("FAIL full_pushpop got mreq %b gnt %b rv %b exp 1 001 001", mem_req, gnt, rvalid); end
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 64'hCAFE_F00D_1234_5678 || mem_be !== 8'hA5 || mem_addr !== 48'h40) begin errors++; $display("FAIL full_payload got we %b d %h be %h a %h", mem_we, mem_wdata, mem_be, mem_addr); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    set_req(2, BASE + 48'h200, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_req(0, BASE + 48'h100, 1'b0, '0, '0);
      settle();
      checks++; if (mem_req !== 1'b1 || gnt !== '0 || mem_addr !== 48'h200) begin errors++; $display("FAIL lock_hold k=%0d got mreq %b gnt %b addr %h exp 1 000 200", k, mem_req, gnt, mem_addr); end
      next_cycle();
    end
    mem_gnt = 1'b1;
    settle();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL lock_gnt2 got %b exp 100", gnt); end
    next_cycle(); drop_req(2); settle();
    checks++; if (gnt !== 3'b001 || mem_addr !== 48'h100) begin errors++; $display("FAIL lock_gnt0 got %b addr %h exp 001 100", gnt, mem_addr); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_routing();
    do_reset();
    set_req(0, BASE + 48'h8, 1'b0, '0, '0);
    set_req(2, BASE + 48'h18, 1'b0, '0, '0);
    mem_gnt = 1'b1;
    settle();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL route_g0 got %b exp 001", gnt); end
    next_cycle(); drop_req(0); settle();
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL route_g2 got %b exp 100", gnt); end
    next_cycle(); drop_req(2); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hAA; settle();
    checks++; if (rvalid !== 3'b001 || rdata !== 64'hAA || err !== 1'b0) begin errors++; $display("FAIL route_r0 got %b/%h err %b exp 001/aa 0", rvalid, rdata, err); end
    next_cycle(); mem_rdata = 64'hBB; settle();
    checks++; if (rvalid !== 3'b100 || rdata !== 64'hBB) begin errors++; $display("FAIL route_r2 got %b/%h exp 100/bb", rvalid, rdata); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] e;
    do_reset();
    set_req(0, BASE + 48'h20, 1'b0, '0, '0);
    set_req(1, BASE + 48'h28, 1'b0, '0, '0);
    mem_gnt = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b1; mem_rvalid = 1'b1;
    settle();
    checks++; if (gnt !== '0 || mem_req !== 1'b0 || rvalid !== '0 || err !== 1'b0) begin errors++; $display("FAIL midrst_quiet got gnt %b mreq %b rv %b err %b exp 0", gnt, mem_req, rvalid, err); end
    next_cycle();
    mem_rvalid = 1'b0;
    drop_req(1);
    set_req(2, BASE + 48'h30, 1'b0, '0, '0);
    rst = 1'b0;
    // Four grants must fit before the FIFO fills: stale entries would stall earlier.
    for (int k = 0; k < MAXO; k++) begin
      settle();
      e = (QOS || k % 2 == 0) ? 3'b001 : 3'b100;
      checks++; if (gnt !== e) begin errors++; $display("FAIL midrst_gnt k=%0d got %b exp %b", k, gnt, e); end
      next_cycle();
    end
    settle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_full got mreq %b exp 0", mem_req); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_qos();
    logic [N-1:0] e;
    do_reset();
    set_req(0, BASE + 48'h0, 1'b0, '0, '0);
    set_req(1, BASE + 48'h8, 1'b0, '0, '0);
    mem_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = (k > 0);
      settle();
      e = (QOS || k % 2 == 0) ? 3'b001 : 3'b010;
      checks++; if (gnt !== e) begin errors++; $display("FAIL qos_gnt k=%0d got %b exp %b", k, gnt, e); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int w;
    bit inr, pop, e_mreq, hs, eg;
    logic [N-1:0]  e_gnt, e_rv;
    logic          e_err;
    logic [DW-1:0] e_rdata;
    do_reset();
    exp_q = {};
    m_ptr = 0; m_lock = -1; m_err = -1;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i] = 1'b1;
          p_addr[i] = pick_addr();
          p_we[i] = 1'($urandom_range(0, 1));
          p_wdata[i] = {$urandom, $urandom};
          p_be[i] = 8'($urandom_range(0, 255));
        end
        req[i] = act[i];
        addr[i*AW +: AW] = p_addr[i];
        we[i] = p_we[i];
        wdata[i*DW +: DW] = p_wdata[i];
        be[i*BW +: BW] = p_be[i];
      end
      mem_gnt = ($urandom_range(0, 3) != 0);
      mem_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_rdata = {$urandom, $urandom};

      w = model_winner();
      inr = (w >= 0) && in_window(p_addr[w]);
      pop = mem_rvalid;
      e_mreq = inr && (exp_q.size() < MAXO || pop);
      hs = e_mreq && mem_gnt;
      eg = (w >= 0) && !inr && exp_q.size() == 0 && m_err < 0;
      e_gnt = (hs || eg) ? N'(1) << w : '0;
      e_rv = '0; e_err = 1'b0; e_rdata = '0;
      if (m_err >= 0) begin
        e_rv = N'(1) << m_err; e_err = 1'b1;
      end else if (pop) begin
        e_rv = N'(1) << exp_q[0]; e_rdata = mem_rdata;
      end

      settle();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got %b exp %b", cyc, gnt, e_gnt); end
      checks++; if (mem_req !== e_mreq) begin errors++; $display("FAIL rnd_mreq cyc=%0d got %b exp %b", cyc, mem_req, e_mreq); end
      checks++; if (rvalid !== e_rv || err !== e_err) begin errors++; $display("FAIL rnd_rsp cyc=%0d got %b err %b exp %b err %b", cyc, rvalid, err, e_rv, e_err); end
      checks++; if (dbg_rsp_err !== (m_err >= 0)) begin errors++; $display("FAIL rnd_dbg cyc=%0d got %b exp %b", cyc, dbg_rsp_err, (m_err >= 0)); end
      if (e_rv != '0) begin
        checks++; if (rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h exp %h", cyc, rdata, e_rdata); end
      end
      if (e_mreq) begin
        checks++; if (mem_addr !== p_addr[w] - BASE || mem_we !== p_we[w] || mem_wdata !== p_wdata[w] || mem_be !== p_be[w]) begin
          errors++; $display("FAIL rnd_payload cyc=%0d got a %h we %b d %h be %h exp a %h we %b d %h be %h", cyc, mem_addr, mem_we, mem_wdata, mem_be, p_addr[w] - BASE, p_we[w], p_wdata[w], p_be[w]);
        end
      end

      if (pop) void'(exp_q.pop_front());
      if (hs) exp_q.push_back(2'(w));
      m_err = eg ? w : -1;
      if (hs || eg) begin
        m_ptr = (w + 1) % N;
        act[w] = 1'b0;
      end
      if (hs) m_lock = -1;
      else if (e_mreq) m_lock = w;
      next_cycle();
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_out_of_range();
    test_boundary();
    test_fifo_full();
    test_lock();
    test_routing();
    test_reset_midop();
    test_qos();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
